// File: rtl/decode_3to8_seq.sv
// ---------------------------------------------------------------------------
// decode_3to8_seq
//
// Sequenced 3-to-8 one-hot decoder. A 3-bit code and a 2-bit mode arrive over
// a valid/ready handshake and drive a registered one-hot bus in one of these
// ways:
//   - held indefinitely (HOLD)
//   - pulsed for PULSE_LEN cycles (PULSE)
//   - swept upward from the code to 7, DWELL cycles per position (SWEEP)
//   - cleared (CLEAR)
// Typical uses are LED / digit-select driving and stimulus for the 8-to-3
// one-hot encoder blocks.
//
// Parameters:
//   PULSE_LEN  cycles y stays active in PULSE mode (1..255)
//   DWELL      cycles each position stays active in SWEEP mode (1..255)
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous reset, active-high
//   en        in   global enable; low freezes the FSM and blanks y
//   in_valid  in   command valid
//   in_ready  out  command accept (combinational from state and en)
//   in_code   in   [2:0] index to decode
//   in_mode   in   [1:0] 00 HOLD, 01 PULSE, 10 SWEEP, 11 CLEAR
//   y         out  [7:0] one-hot output, gated by en
//   idx       out  [2:0] currently active index, 0 when idle
//   busy      out  high in PULSE and SWEEP
//   done      out  one-cycle pulse when PULSE or SWEEP completes
//
// States:
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | y cleared, waiting for a command
//   HOLD  | y held at the last HOLD code, new commands still accepted
//   PULSE | y active for PULSE_LEN cycles, then back to IDLE with done
//   SWEEP | y steps from the code up to 7, DWELL cycles each, then done
// ---------------------------------------------------------------------------
module decode_3to8_seq #(
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned DWELL     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_code,
    input  logic [1:0] in_mode,
    output logic [7:0] y,
    output logic [2:0] idx,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_SWEEP = 2'd3;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_PULSE = 2'b01;
    localparam logic [1:0] MODE_SWEEP = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    // The counter is a down-counter: the cycle loaded with the reload value
    // is the first active cycle, and terminal count (zero) is the last one.
    localparam logic [7:0] PULSE_RELOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] DWELL_RELOAD = 8'(DWELL - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] y_q,     y_d;
    logic [2:0] idx_q,   idx_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;
    logic [7:0] cnt_q,   cnt_d;

    logic       accept;
    logic       cnt_tc;
    logic [7:0] code_onehot;

    assign in_ready    = en && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
    assign accept      = in_valid && in_ready;
    assign cnt_tc      = (cnt_q == 8'd0);
    assign code_onehot = 8'd1 << in_code;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        // done is a strobe; it never persists, not even while frozen.
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        if (en) begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        case (in_mode)
                            MODE_HOLD: begin
                                state_d = ST_HOLD;
                                y_d     = code_onehot;
                                idx_d   = in_code;
                                busy_d  = 1'b0;
                                cnt_d   = 8'd0;
                            end
                            MODE_PULSE: begin
                                state_d = ST_PULSE;
                                y_d     = code_onehot;
                                idx_d   = in_code;
                                busy_d  = 1'b1;
                                cnt_d   = PULSE_RELOAD;
                            end
                            MODE_SWEEP: begin
                                state_d = ST_SWEEP;
                                y_d     = code_onehot;
                                idx_d   = in_code;
                                busy_d  = 1'b1;
                                cnt_d   = DWELL_RELOAD;
                            end
                            MODE_CLEAR: begin
                                state_d = ST_IDLE;
                                y_d     = 8'h00;
                                idx_d   = 3'd0;
                                busy_d  = 1'b0;
                                cnt_d   = 8'd0;
                            end
                        endcase
                    end
                end

                ST_PULSE: begin
                    if (cnt_tc) begin
                        state_d = ST_IDLE;
                        y_d     = 8'h00;
                        idx_d   = 3'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end

                ST_SWEEP: begin
                    if (cnt_tc) begin
                        if (idx_q == 3'd7) begin
                            // Last position has dwelt; no wrap-around.
                            state_d = ST_IDLE;
                            y_d     = 8'h00;
                            idx_d   = 3'd0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            // Shifting keeps y one-hot; idx < 7 here so the
                            // set bit never falls off the top.
                            y_d   = y_q << 1;
                            idx_d = idx_q + 3'd1;
                            cnt_d = DWELL_RELOAD;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    y_d     = 8'h00;
                    idx_d   = 3'd0;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= 8'h00;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // en blanks the port only; y_q keeps its value so the command resumes.
    assign y    = y_q & {8{en}};
    assign idx  = idx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_decode_3to8_seq.sv
module tb_decode_3to8_seq;

    logic       clk;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic [1:0] in_mode;
    logic [7:0] y;
    logic [2:0] idx;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;

    decode_3to8_seq #(
        .PULSE_LEN(2),
        .DWELL    (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_code (in_code),
        .in_mode (in_mode),
        .y       (y),
        .idx     (idx),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge and sample 1 ns later; y must never be multi-hot.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot", 32'($onehot0(y)), 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_y"},    32'(y),    32'h00);
        chk({tag, "_idx"},  32'(idx),  32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_y;
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        en       = 1'b1;
        in_valid = 1'b0;
        in_code  = 3'd0;
        in_mode  = 2'b00;

        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_idle("rst");
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // HOLD 5, then HOLD 2 with no zero gap
        in_valid = 1'b1; in_code = 3'd5; in_mode = 2'b00;
        tick();
        chk("hold5_y",    32'(y),    32'h20);
        chk("hold5_idx",  32'(idx),  32'd5);
        chk("hold5_busy", 32'(busy), 32'd0);
        chk("hold5_rdy",  32'(in_ready), 32'd1);
        in_code = 3'd2;
        tick();
        chk("hold2_y",   32'(y),   32'h04);
        chk("hold2_idx", 32'(idx), 32'd2);

        // HOLD 1 then CLEAR
        in_code = 3'd1;
        tick();
        chk("hold1_y", 32'(y), 32'h02);
        in_mode = 2'b11;
        tick();
        chk_idle("clear");
        chk("clear_done", 32'(done), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("clear_done2", 32'(done), 32'd0);

        // PULSE code 3, with a held HOLD-6 command waiting behind it
        in_valid = 1'b1; in_code = 3'd3; in_mode = 2'b01;
        tick();
        chk("pulse_c0_y",    32'(y),        32'h08);
        chk("pulse_c0_busy", 32'(busy),     32'd1);
        chk("pulse_c0_rdy",  32'(in_ready), 32'd0);
        in_code = 3'd6; in_mode = 2'b00;
        tick();
        chk("pulse_c1_y",   32'(y),        32'h08);
        chk("pulse_c1_rdy", 32'(in_ready), 32'd0);
        chk("pulse_c1_done", 32'(done),    32'd0);
        tick();
        chk_idle("pulse_end");
        chk("pulse_end_done", 32'(done),     32'd1);
        chk("pulse_end_rdy",  32'(in_ready), 32'd1);
        tick();
        chk("pulse_next_y",    32'(y),    32'h40);
        chk("pulse_next_idx",  32'(idx),  32'd6);
        chk("pulse_next_done", 32'(done), 32'd0);
        in_mode = 2'b11;
        tick();
        in_valid = 1'b0;
        chk_idle("pulse_clr");

        // SWEEP from 5: 0x20,0x40,0x80 for 4 cycles each
        in_valid = 1'b1; in_code = 3'd5; in_mode = 2'b10;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_y = 8'h20 << (i / 4);
            chk("sw5_y",    32'(y),    32'(exp_y));
            chk("sw5_idx",  32'(idx),  32'(5 + i / 4));
            chk("sw5_busy", 32'(busy), 32'd1);
            chk("sw5_done", 32'(done), 32'd0);
            tick();
        end
        chk_idle("sw5_end");
        chk("sw5_end_done", 32'(done), 32'd1);
        tick();
        chk("sw5_post_done", 32'(done), 32'd0);

        // SWEEP from 7: single dwell
        in_valid = 1'b1; in_code = 3'd7; in_mode = 2'b10;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("sw7_y",    32'(y),    32'h80);
            chk("sw7_done", 32'(done), 32'd0);
            tick();
        end
        chk_idle("sw7_end");
        chk("sw7_end_done", 32'(done), 32'd1);
        tick();

        // SWEEP from 5 with en dropped for 3 edges in the middle of code 6
        in_valid = 1'b1; in_code = 3'd5; in_mode = 2'b10;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_y = 8'h20 << (i / 4);
            if (i == 5) begin
                en = 1'b0;
                #1;
                chk("en_y",   32'(y),        32'h00);
                chk("en_rdy", 32'(in_ready), 32'd0);
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("en_fz_y",    32'(y),    32'h00);
                    chk("en_fz_idx",  32'(idx),  32'd6);
                    chk("en_fz_busy", 32'(busy), 32'd1);
                    chk("en_fz_done", 32'(done), 32'd0);
                end
                en = 1'b1;
                #1;
            end
            chk("en_sw_y",    32'(y),    32'(exp_y));
            chk("en_sw_idx",  32'(idx),  32'(5 + i / 4));
            chk("en_sw_done", 32'(done), 32'd0);
            tick();
        end
        chk_idle("en_end");
        chk("en_end_done", 32'(done), 32'd1);
        tick();

        // Reset for 2 cycles in the middle of a long SWEEP from 0
        in_valid = 1'b1; in_code = 3'd0; in_mode = 2'b10;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("rs_pre_y", 32'(y), 32'h02);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_idle("rs_in");
            chk("rs_in_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rs_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("rs_post_done", 32'(done), 32'd0);
            chk("rs_post_y",    32'(y),    32'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
